// File: rtl/muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit with architectural HI/LO registers.
// Ports: clk, reset (async active-low), start/op/busa/busb launch an operation,
//   mthi/mtlo move busa into HI/LO when idle; hi/lo/busy/done report status.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] busa,
    input  logic [WIDTH-1:0] busb,
    input  logic             mthi,
    input  logic             mtlo,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             div_q, div_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             div0_q, div0_d;
    // acc holds product high half / remainder; low holds multiplier / quotient
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] low_q, low_d;
    // dvs holds multiplicand magnitude or divisor magnitude
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_sh;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_neg;

    always_comb begin
        mag_a    = (op[0] && busa[WIDTH-1]) ? -busa : busa;
        mag_b    = (op[0] && busb[WIDTH-1]) ? -busb : busb;
        mul_sum  = {1'b0, acc_q} + (low_q[0] ? {1'b0, dvs_q} : '0);
        div_sh   = {acc_q, low_q[WIDTH-1]};
        div_diff = div_sh - {1'b0, dvs_q};
        // no borrow means the shifted remainder covers the divisor
        div_ok   = ~div_diff[WIDTH];
        prod     = {acc_q, low_q};
        prod_neg = -prod;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        div_d   = div_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        div0_d  = div0_q;
        acc_d   = acc_q;
        low_d   = low_q;
        dvs_d   = dvs_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = CALC;
                    cnt_d   = '0;
                    div_d   = op[1];
                    acc_d   = '0;
                    low_d   = op[1] ? mag_a : mag_b;
                    dvs_d   = op[1] ? mag_b : mag_a;
                    negq_d  = op[0] & (busa[WIDTH-1] ^ busb[WIDTH-1]);
                    negr_d  = op[0] & busa[WIDTH-1];
                    div0_d  = op[1] & (busb == '0);
                end else begin
                    if (mthi) hi_d = busa;
                    if (mtlo) lo_d = busa;
                end
            end
            CALC: begin
                if (div_q) begin
                    acc_d = div_ok ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
                    low_d = {low_q[WIDTH-2:0], div_ok};
                end else begin
                    acc_d = mul_sum[WIDTH:1];
                    low_d = {mul_sum[0], low_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(WIDTH-1)) state_d = FIX;
            end
            FIX: begin
                if (div_q) begin
                    // divide by zero: quotient all ones, remainder
                    // restores to the original dividend via sign fix
                    lo_d = div0_q ? '1 : (negq_q ? -low_q : low_q);
                    hi_d = negr_q ? -acc_q : acc_q;
                end else begin
                    {hi_d, lo_d} = negq_q ? prod_neg : prod;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            div_q   <= 1'b0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            div0_q  <= 1'b0;
            acc_q   <= '0;
            low_q   <= '0;
            dvs_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            div_q   <= div_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            div0_q  <= div0_d;
            acc_q   <= acc_d;
            low_q   <= low_d;
            dvs_q   <= dvs_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
        end
    end

    assign hi   = hi_q;
    assign lo   = lo_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit.
// Checks reset, moves, all four ops, divide edge cases, abort and ignore rules.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] busa = '0;
    logic [31:0] busb = '0;
    logic        mthi = 1'b0;
    logic        mtlo = 1'b0;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;

    int errs = 0;
    int checks = 0;

    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .busa(busa), .busb(busb), .mthi(mthi), .mtlo(mtlo),
        .hi(hi), .lo(lo), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo,
                          input bit poke);
        int          nbusy;
        int          ndone;
        bit          held;
        logic [31:0] hi0;
        logic [31:0] lo0;
        @(negedge clk);
        hi0 = hi;
        lo0 = lo;
        op = o;
        busa = a;
        busb = b;
        start = 1'b1;
        nbusy = 0;
        ndone = 0;
        held = 1'b1;
        for (int i = 1; i <= 33; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (busy) nbusy++;
            if (done) ndone++;
            if (hi !== hi0 || lo !== lo0) held = 1'b0;
            if (poke && i == 5) begin
                start = 1'b1;
                mthi = 1'b1;
                mtlo = 1'b1;
                op = ~o;
                busa = ~a;
                busb = ~b;
            end
            if (poke && i == 6) begin
                mthi = 1'b0;
                mtlo = 1'b0;
            end
        end
        @(negedge clk);
        chk({tag, "_nbusy"}, 64'(nbusy), 64'd33);
        chk({tag, "_early_done"}, 64'(ndone), 64'd0);
        chk({tag, "_held"}, 64'(held), 64'd1);
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_busy_end"}, 64'(busy), 64'd0);
        chk({tag, "_hi"}, 64'(hi), 64'(ehi));
        chk({tag, "_lo"}, 64'(lo), 64'(elo));
        @(negedge clk);
        chk({tag, "_done_clr"}, 64'(done), 64'd0);
    endtask

    initial begin
        int ndone;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        busa = 32'hA5A5_5A5A;
        mthi = 1'b1;
        mtlo = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        mtlo = 1'b0;
        chk("mthilo_hi", 64'(hi), 64'hA5A5_5A5A);
        chk("mthilo_lo", 64'(lo), 64'hA5A5_5A5A);

        #2 reset = 1'b0;
        #1;
        chk("async_hi", 64'(hi), 64'd0);
        chk("async_lo", 64'(lo), 64'd0);
        chk("async_bd", 64'({busy, done}), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        busa = 32'h1234_5678;
        mthi = 1'b1;
        @(negedge clk);
        mthi = 1'b0;
        chk("mthi_hi", 64'(hi), 64'h1234_5678);
        chk("mthi_lo", 64'(lo), 64'd0);

        busa = 32'h0BAD_F00D;
        busb = 32'd2;
        op = 2'b00;
        start = 1'b1;
        mtlo = 1'b1;
        @(negedge clk);
        start = 1'b0;
        mtlo = 1'b0;
        chk("start_wins_lo", 64'(lo), 64'd0);
        chk("start_wins_busy", 64'(busy), 64'd1);
        repeat (33) @(negedge clk);
        chk("start_wins_res", 64'({hi, lo}), 64'h0000_0000_175B_E01A);

        run_op("multu_max", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        run_op("mult_neg", 2'b01, 32'hFFFF_FFFE, 32'h0000_0003,
               32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
        run_op("div_neg", 2'b11, 32'hFFFF_FFF9, 32'h0000_0002,
               32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
        run_op("divu", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
        run_op("divu_z", 2'b10, 32'h55, 32'h0,
               32'h0000_0055, 32'hFFFF_FFFF, 1'b0);
        run_op("div_z", 2'b11, 32'hFFFF_FFF9, 32'h0,
               32'hFFFF_FFF9, 32'hFFFF_FFFF, 1'b0);
        run_op("div_ovf", 2'b11, 32'h8000_0000, 32'hFFFF_FFFF,
               32'h0000_0000, 32'h8000_0000, 1'b0);
        run_op("mult_pp", 2'b01, 32'hFFFF_FFF9, 32'hFFFF_FFFD,
               32'h0000_0000, 32'h0000_0015, 1'b0);

        @(negedge clk);
        op = 2'b00;
        busa = 32'd3;
        busb = 32'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("abort_hilo", 64'({hi, lo}), 64'd0);
        chk("abort_bd", 64'({busy, done}), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) ndone++;
        end
        chk("abort_quiet", 64'(ndone), 64'd0);

        run_op("restart", 2'b00, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        run_op("ignore", 2'b00, 32'd3, 32'd7, 32'd0, 32'd21, 1'b1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
